// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader.
// Parses a framed byte stream (0xA5, LEN_LO, LEN_HI, 4*N payload bytes, CHK), writes each
// little-endian 32-bit word to the instruction-memory write port, and releases the core reset
// only after the XOR checksum over the payload matches.
// The length is carried in 16 bits, so ADDR_W must not exceed 15.

module imem_boot_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [7:0]        byte_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              core_rst_no,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam int unsigned CntW     = ADDR_W + 1;
  localparam logic [16:0] MaxWords = 17'(2 ** ADDR_W);
  localparam logic [7:0]  SyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [CntW-1:0]   word_cnt_q;
  logic [15:0]       len_q;
  logic [7:0]        chk_q;
  logic [31:0]       word_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_data_q;
  logic              done_q;
  logic              error_q;

  logic              accept;
  logic [15:0]       len_d;
  logic [31:0]       word_d;
  logic              last_word;

  // Handshake and next-value helpers for the FSM.
  always_comb begin
    accept    = byte_valid_i & byte_ready_o;
    len_d     = {byte_i, len_q[7:0]};
    // First byte of a word ends up in bits [7:0] after four shifts.
    word_d    = {byte_i, word_q[31:8]};
    // Widened so N = 2^ADDR_W is reached without the counter wrapping.
    last_word = ((17'(word_cnt_q) + 17'd1) == {1'b0, len_q});
  end

  // Frame parser FSM with registered write port and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      chk_q       <= '0;
      word_q      <= '0;
      imem_we_q   <= 1'b0;
      imem_addr_q <= '0;
      imem_data_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      if (accept) begin
        unique case (state_q)
          StIdle: begin
            if (byte_i == SyncByte) begin
              state_q    <= StLenLo;
              byte_cnt_q <= '0;
              word_cnt_q <= '0;
              chk_q      <= '0;
            end
          end
          StLenLo: begin
            len_q[7:0] <= byte_i;
            state_q    <= StLenHi;
          end
          StLenHi: begin
            len_q[15:8] <= byte_i;
            if (len_d == 16'd0 || {1'b0, len_d} > MaxWords) begin
              state_q <= StErr;
              error_q <= 1'b1;
            end else begin
              state_q <= StData;
            end
          end
          StData: begin
            word_q     <= word_d;
            chk_q      <= chk_q ^ byte_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_we_q   <= 1'b1;
              imem_addr_q <= word_cnt_q[ADDR_W-1:0];
              imem_data_q <= word_d;
              word_cnt_q  <= word_cnt_q + CntW'(1);
              if (last_word) begin
                state_q <= StChk;
              end
            end
          end
          StChk: begin
            if (byte_i == chk_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StErr;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from state or driven straight from registers.
  always_comb begin
    byte_ready_o = (state_q != StDone) && (state_q != StErr);
    busy_o       = (state_q == StLenLo) || (state_q == StLenHi) ||
                   (state_q == StData)  || (state_q == StChk);
    imem_we_o    = imem_we_q;
    imem_addr_o  = imem_addr_q;
    imem_data_o  = imem_data_q;
    done_o       = done_q;
    error_o      = error_q;
    core_rst_no  = done_q;
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed testbench for imem_boot_loader.

module tb_imem_boot_loader;

  localparam int unsigned ADDR_W = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [7:0]        byte_i = 8'h00;
  logic              byte_valid_i = 1'b0;
  logic              byte_ready_o;
  logic              imem_we_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic [31:0]       imem_data_o;
  logic              core_rst_no;
  logic              busy_o;
  logic              done_o;
  logic              error_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] wr_addr [64];
  logic [31:0]       wr_data [64];
  int                wr_n = 0;

  logic [7:0] frame [12] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00, 8'h90};

  imem_boot_loader #(.ADDR_W(ADDR_W)) u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .core_rst_no  (core_rst_no),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every cycle with the write strobe high.
  always @(negedge clk_i) begin
    if (imem_we_o && wr_n < 64) begin
      wr_addr[wr_n] = imem_addr_o;
      wr_data[wr_n] = imem_data_o;
      wr_n = wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    byte_valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Present one byte for one cycle; ready must be high while the loader is listening.
  task automatic send_byte(input logic [7:0] b);
    byte_i = b;
    byte_valid_i = 1'b1;
    @(negedge clk_i);
    if (!byte_ready_o) check("ready_on_send", {31'd0, byte_ready_o}, 32'd1);
    @(posedge clk_i);
    #1;
    byte_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] chk, input bit gaps);
    for (int i = 0; i < 12; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk_i);
      if (gaps) #1;
      send_byte((i == 11) ? chk : frame[i]);
    end
  endtask

  task automatic expect_writes(input string tag, input int base);
    repeat (2) @(posedge clk_i);
    #1;
    check({tag, "_wr_count"}, wr_n - base, 2);
    check({tag, "_addr0"}, {24'd0, wr_addr[base]}, 32'd0);
    check({tag, "_data0"}, wr_data[base], 32'h0000_0013);
    check({tag, "_addr1"}, {24'd0, wr_addr[base+1]}, 32'd1);
    check({tag, "_data1"}, wr_data[base+1], 32'h0010_0093);
  endtask

  initial begin
    int base;

    // 1: reset state
    apply_reset();
    @(negedge clk_i);
    check("rst_core", {31'd0, core_rst_no}, 32'd0);
    check("rst_ready", {31'd0, byte_ready_o}, 32'd1);
    check("rst_we", {31'd0, imem_we_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_err", {31'd0, error_o}, 32'd0);
    check("rst_addr", {24'd0, imem_addr_o}, 32'd0);
    check("rst_data", imem_data_o, 32'd0);
    @(posedge clk_i);
    #1;

    // 2: good frame back-to-back
    base = wr_n;
    send_frame(8'h90, 1'b0);
    check("t2_done_next", {31'd0, done_o}, 32'd1);
    check("t2_core_next", {31'd0, core_rst_no}, 32'd1);
    expect_writes("t2", base);
    check("t2_ready", {31'd0, byte_ready_o}, 32'd0);
    check("t2_busy", {31'd0, busy_o}, 32'd0);
    check("t2_err", {31'd0, error_o}, 32'd0);
    check("t2_hold_addr", {24'd0, imem_addr_o}, 32'd1);
    check("t2_hold_data", imem_data_o, 32'h0010_0093);

    // 3: bad checksum
    apply_reset();
    base = wr_n;
    send_frame(8'h91, 1'b0);
    check("t3_err_next", {31'd0, error_o}, 32'd1);
    expect_writes("t3", base);
    check("t3_done", {31'd0, done_o}, 32'd0);
    check("t3_core", {31'd0, core_rst_no}, 32'd0);
    check("t3_ready", {31'd0, byte_ready_o}, 32'd0);

    // 4a: junk then zero length
    apply_reset();
    base = wr_n;
    send_byte(8'h00);
    send_byte(8'hFF);
    check("t4_junk_busy", {31'd0, busy_o}, 32'd0);
    send_byte(8'hA5);
    check("t4_sync_busy", {31'd0, busy_o}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    check("t4_zero_err", {31'd0, error_o}, 32'd1);
    check("t4_zero_ready", {31'd0, byte_ready_o}, 32'd0);
    check("t4_zero_core", {31'd0, core_rst_no}, 32'd0);

    // 4b: length 257 exceeds capacity
    apply_reset();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    check("t4_big_err", {31'd0, error_o}, 32'd1);
    check("t4_big_busy", {31'd0, busy_o}, 32'd0);
    repeat (3) @(posedge clk_i);
    #1;
    check("t4_no_writes", wr_n - base, 0);

    // 5: random gaps between bytes
    apply_reset();
    base = wr_n;
    send_frame(8'h90, 1'b1);
    check("t5_done", {31'd0, done_o}, 32'd1);
    expect_writes("t5", base);
    check("t5_core", {31'd0, core_rst_no}, 32'd1);
    check("t5_err", {31'd0, error_o}, 32'd0);

    // 6: reset mid-word, then full frame
    apply_reset();
    base = wr_n;
    for (int i = 0; i < 5; i++) send_byte(frame[i]);
    check("t6_mid_busy", {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy_o}, 32'd0);
    check("t6_rst_ready", {31'd0, byte_ready_o}, 32'd1);
    check("t6_rst_we", {31'd0, imem_we_o}, 32'd0);
    check("t6_rst_core", {31'd0, core_rst_no}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check("t6_partial_writes", wr_n - base, 0);
    send_frame(8'h90, 1'b0);
    check("t6_done", {31'd0, done_o}, 32'd1);
    expect_writes("t6", base);
    check("t6_core", {31'd0, core_rst_no}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle core. Receives a framed byte stream (from a UART receiver or debug bridge), assembles little-endian 32-bit instructions and writes them into the instruction memory write port.
- Holds the core in reset until a complete frame with a valid checksum has been loaded, then releases it.
- Word addresses match the core's fetch indexing: PC[ADDR_W+1:2].

Parameters:
- ADDR_W, 8, instruction-memory word-address width. Capacity is 2^ADDR_W words (256 words = 1 KiB).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- byte_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_i is valid this cycle.
- byte_ready_o  output  1  loader accepts a byte this cycle. A byte transfers when byte_valid_i and byte_ready_o are both 1.
- imem_we_o  output  1  instruction-memory write strobe, one cycle per word.
- imem_addr_o  output  ADDR_W  word address for the write.
- imem_data_o  output  32  instruction word to write.
- core_rst_no  output  1  core reset, active-low. 0 holds the core in reset.
- busy_o  output  1  frame in progress.
- done_o  output  1  load completed successfully (sticky).
- error_o  output  1  frame rejected (sticky).

Behaviour:
- Frame format, in byte order:
  - 0xA5 sync byte.
  - LEN_LO, LEN_HI: word count N, 16-bit little-endian.
  - 4N payload bytes, each word little-endian (first byte goes to bits [7:0]).
  - CHK byte: XOR of all 4N payload bytes. Sync and length bytes are not included.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR. Reset state is IDLE.
- Transitions (all on an accepted byte unless noted):
  - IDLE: 0xA5 -> LEN_LO. Any other byte is consumed and ignored.
  - LEN_LO: latch low byte -> LEN_HI.
  - LEN_HI: latch high byte. If N==0 or N>2^ADDR_W -> ERR, otherwise -> DATA.
  - DATA: the 2-bit byte counter shifts each byte into the word register and XORs it into the checksum register. On the 4th byte of word N-1 -> CHK.
  - CHK: if byte == checksum register -> DONE, otherwise -> ERR.
  - DONE and ERR are terminal until rst_ni is asserted.
- byte_ready_o is decoded from state: 1 in IDLE, LEN_LO, LEN_HI, DATA and CHK; 0 in DONE and ERR.
- Memory write:
  - Registered. The cycle after the 4th byte of word k is accepted: imem_we_o=1 for exactly one cycle, imem_addr_o=k, imem_data_o=assembled word.
  - The write of the last word occurs while the FSM is in CHK. It must not be lost or delayed by the CHK byte arriving in that same cycle.
  - imem_addr_o and imem_data_o hold their last value when imem_we_o=0.
  - The word counter is ADDR_W+1 bits wide, so N=2^ADDR_W does not wrap before the compare. The last address is 2^ADDR_W-1.
- Words already written when a frame is rejected stay in memory. The core is not released.
- Status outputs:
  - busy_o=1 in LEN_LO, LEN_HI, DATA and CHK.
  - done_o and core_rst_no go to 1 the cycle after a matching CHK byte is accepted, and stay 1.
  - error_o goes to 1 the cycle after the rejecting byte is accepted, and stays 1. core_rst_no stays 0 in ERR.
- Gaps (byte_valid_i=0) may occur between any bytes. There is no timeout and state is held.
- Reset values: imem_we_o=0, imem_addr_o=0, imem_data_o=0, core_rst_no=0, busy_o=0, done_o=0, error_o=0, byte_ready_o=1 (IDLE). Byte counter, word counter, length and checksum registers reset to 0.
- Reset asserted mid-frame aborts immediately: all outputs return to reset values and the next frame must begin with 0xA5.

Test Plan:
1. Assert rst_ni=0, release -> core_rst_no=0, byte_ready_o=1, imem_we_o=0, busy_o=0, done_o=0, error_o=0.
2. Send A5 02 00 13 00 00 00 93 00 10 00 90 back-to-back -> write addr 0 = 0x00000013, then addr 1 = 0x00100093, one imem_we_o pulse each; done_o=1 and core_rst_no=1 one cycle after 0x90 is accepted; byte_ready_o=0 afterwards.
3. Same frame with CHK=0x91 -> both words written, error_o=1, core_rst_no stays 0, byte_ready_o=0, done_o=0.
4. Send 00 FF A5 00 00 -> 00 and FF are ignored, ERR after LEN_HI. Separately, length 01 01 (257) with ADDR_W=8 -> ERR with no imem_we_o pulse.
5. Test 2 frame with random 0-3 idle cycles between bytes (byte_valid_i=0) -> identical writes and final state; no extra or missing imem_we_o pulses.
6. Pulse rst_ni low after 5 bytes of the test 2 frame (mid-word), then send the full test 2 frame -> outputs return to reset values during reset; the second frame loads correctly and sets done_o.
